// File: rtl/ov7670_emu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ov7670_emu_pkg
// Brief    : Shared types and constants for the OV7670 stream emulator.
// Revision : 1.0
// ============================================================================
package ov7670_emu_pkg;

    typedef logic [2:0] emu_state_t;
    localparam emu_state_t ST_IDLE   = 3'd0;
    localparam emu_state_t ST_VSYNC  = 3'd1;
    localparam emu_state_t ST_VBACK  = 3'd2;
    localparam emu_state_t ST_ACTIVE = 3'd3;
    localparam emu_state_t ST_VFRONT = 3'd4;

    typedef enum logic [1:0] {
        PAT_RAMP    = 2'd0,
        PAT_BARS    = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_DIAG    = 2'd3
    } emu_pattern_e;

    localparam logic [7:0] CHROMA_BYTE = 8'h80;
    localparam logic [7:0] CHECKER_HI  = 8'hF0;
    localparam logic [7:0] CHECKER_LO  = 8'h10;
    localparam int         BAR_WIDTH   = 80;
    localparam int         BAR_STEP    = 36;

endpackage
`default_nettype wire

// File: rtl/ov7670_emu_if.sv
`default_nettype none
// ============================================================================
// Module   : ov7670_emu_if
// Brief    : OV7670-style parallel pixel bus (vsync, href, data).
// Revision : 1.0
// ============================================================================
interface ov7670_emu_if;
    logic       vsync;
    logic       href;
    logic [7:0] data;

    modport master (output vsync, output href, output data);
    modport slave  (input  vsync, input  href, input  data);
endinterface
`default_nettype wire

// File: rtl/ov7670_emu_luma.sv
`default_nettype none
// ============================================================================
// Module   : ov7670_emu_luma
// Brief    : Combinational test-pattern luma generator (pattern, x, y, frame).
// Revision : 1.0
// ============================================================================
module ov7670_emu_luma
    import ov7670_emu_pkg::*;
(
    input  emu_pattern_e pattern,
    input  logic [9:0]   x,
    input  logic [9:0]   y,
    input  logic [7:0]   frame_cnt,
    output logic [7:0]   luma
);

    always_comb begin
        luma = x[7:0];
        case (pattern)
            PAT_RAMP:    luma = x[7:0];
            PAT_BARS:    luma = 8'((x / 10'(BAR_WIDTH)) * 10'(BAR_STEP));
            PAT_CHECKER: luma = (x[4] ^ y[4]) ? CHECKER_HI : CHECKER_LO;
            PAT_DIAG:    luma = 8'(x + y + {2'b00, frame_cnt});
            default:     luma = x[7:0];
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ov7670_stream_emulator.sv
`default_nettype none
// ============================================================================
// Module   : ov7670_stream_emulator
// Brief    : VGA-timed OV7670 parallel-output emulator with test patterns.
// Revision : 1.0
// ============================================================================
module ov7670_stream_emulator
    import ov7670_emu_pkg::*;
#(
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int H_BLANK     = 288,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [1:0]         pattern_sel,
    ov7670_emu_if.master       cam,
    output logic               frame_start,
    output logic               busy
);

    localparam logic [10:0] c_line_last    = 11'(2 * IMG_WIDTH + H_BLANK - 1);
    localparam logic [10:0] c_active_bytes = 11'(2 * IMG_WIDTH);
    localparam logic [9:0]  c_vsync_last   = 10'(VSYNC_LINES - 1);
    localparam logic [9:0]  c_vback_last   = 10'(V_BACK - 1);
    localparam logic [9:0]  c_active_last  = 10'(IMG_HEIGHT - 1);
    localparam logic [9:0]  c_vfront_last  = 10'(V_FRONT - 1);

    emu_state_t   r_state, w_state_n;
    logic [10:0]  r_hcnt, w_hcnt_n;
    logic [9:0]   r_lcnt, w_lcnt_n;
    logic [7:0]   r_frame_cnt, w_frame_cnt_n;
    emu_pattern_e r_pattern, w_pattern_n;
    logic [9:0]   w_line_last;

    logic         r_vsync, r_href, r_frame_start, r_busy;
    logic [7:0]   r_data;
    logic         w_vsync_n, w_href_n, w_frame_start_n;
    logic [7:0]   w_data_n, w_luma;

    always_comb begin
        case (r_state)
            ST_VSYNC:  w_line_last = c_vsync_last;
            ST_VBACK:  w_line_last = c_vback_last;
            ST_ACTIVE: w_line_last = c_active_last;
            default:   w_line_last = c_vfront_last;
        endcase
    end

    // Next-state view: the output registers are loaded from these values so
    // every output describes the byte the counters point at after the edge.
    always_comb begin
        w_state_n     = r_state;
        w_hcnt_n      = r_hcnt;
        w_lcnt_n      = r_lcnt;
        w_frame_cnt_n = r_frame_cnt;
        w_pattern_n   = r_pattern;
        if (r_state == ST_IDLE) begin
            if (enable) begin
                w_state_n   = ST_VSYNC;
                w_hcnt_n    = 11'd0;
                w_lcnt_n    = 10'd0;
                w_pattern_n = emu_pattern_e'(pattern_sel);
            end
        end else if (r_hcnt == c_line_last) begin
            w_hcnt_n = 11'd0;
            if (r_lcnt == w_line_last) begin
                w_lcnt_n = 10'd0;
                case (r_state)
                    ST_VSYNC:  w_state_n = ST_VBACK;
                    ST_VBACK:  w_state_n = ST_ACTIVE;
                    ST_ACTIVE: w_state_n = ST_VFRONT;
                    default: begin
                        w_frame_cnt_n = r_frame_cnt + 8'd1;
                        if (enable) begin
                            w_state_n   = ST_VSYNC;
                            w_pattern_n = emu_pattern_e'(pattern_sel);
                        end else begin
                            w_state_n   = ST_IDLE;
                        end
                    end
                endcase
            end else begin
                w_lcnt_n = r_lcnt + 10'd1;
            end
        end else begin
            w_hcnt_n = r_hcnt + 11'd1;
        end
    end

    ov7670_emu_luma u_luma (
        .pattern   (w_pattern_n),
        .x         (w_hcnt_n[10:1]),
        .y         (w_lcnt_n),
        .frame_cnt (w_frame_cnt_n),
        .luma      (w_luma)
    );

    always_comb begin
        w_vsync_n       = (w_state_n == ST_VSYNC);
        w_frame_start_n = (w_state_n == ST_VSYNC) && (r_state != ST_VSYNC);
        w_href_n        = (w_state_n == ST_ACTIVE) && (w_hcnt_n < c_active_bytes);
        w_data_n        = 8'h00;
        if (w_href_n) begin
            w_data_n = w_hcnt_n[0] ? CHROMA_BYTE : w_luma;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_hcnt        <= 11'd0;
            r_lcnt        <= 10'd0;
            r_frame_cnt   <= 8'd0;
            r_pattern     <= PAT_RAMP;
            r_vsync       <= 1'b0;
            r_href        <= 1'b0;
            r_data        <= 8'h00;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_hcnt        <= w_hcnt_n;
            r_lcnt        <= w_lcnt_n;
            r_frame_cnt   <= w_frame_cnt_n;
            r_pattern     <= w_pattern_n;
            r_vsync       <= w_vsync_n;
            r_href        <= w_href_n;
            r_data        <= w_data_n;
            r_frame_start <= w_frame_start_n;
            r_busy        <= (w_state_n != ST_IDLE);
        end
    end

    assign cam.vsync   = r_vsync;
    assign cam.href    = r_href;
    assign cam.data    = r_data;
    assign frame_start = r_frame_start;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: doc/ov7670_stream_emulator.md
# ov7670_stream_emulator

Synthesizable stand-in for the OV7670 sensor's parallel pixel output, driving `vsync`/`href`/`data` into `ov7670_capture` exactly as the camera would. It is used for bring-up and benches with no sensor attached. It emits VGA-timed frames of two bytes per pixel: luma byte first, then a constant chroma byte of 0x80. The luma comes from a selectable test pattern.

## Interface
Parameters:
- `IMG_WIDTH`, 640, active pixels per line.
- `IMG_HEIGHT`, 480, active lines per frame.
- `H_BLANK`, 288, blank bytes after each active line's 2*IMG_WIDTH bytes.
- `VSYNC_LINES`, 3, lines with vsync high.
- `V_BACK`, 17, blank lines after vsync.
- `V_FRONT`, 10, blank lines after the last active line.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  byte clock; this is the pclk seen by the capture side.
- `reset_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  run frames continuously while high.
- `pattern_sel`  in  2  0 ramp, 1 bars, 2 checker, 3 moving diagonal.
- `vsync`  out  1  frame sync, active high.
- `href`  out  1  line valid, high during active bytes.
- `data`  out  8  pixel byte.
- `frame_start`  out  1  one-cycle pulse on the first vsync-high cycle.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, VSYNC, VBACK, ACTIVE, VFRONT.
- Counters:
  - `hcnt` is 11 bits and runs 0..LINE_BYTES-1, where LINE_BYTES = 2*IMG_WIDTH+H_BLANK (1568 at defaults).
  - `lcnt` is 10 bits and counts lines within the current state.
  - `frame_cnt` is 8 bits and wraps.
- `hcnt` runs in every non-IDLE state. `lcnt` increments when `hcnt` wraps; the state advances when `lcnt` reaches that state's line count.
- IDLE -> VSYNC when `enable`=1.
- Fixed sequence VSYNC -> VBACK -> ACTIVE -> VFRONT.
- At the end of VFRONT:
  - `enable`=1 -> VSYNC.
  - `enable`=0 -> IDLE.
- `frame_cnt` increments at the end of VFRONT.
- `enable` dropping mid-frame has no effect until the frame completes. Frames are never truncated.
- `pattern_sel` is latched on entry to VSYNC; changes mid-frame are ignored.
- ACTIVE line:
  - `href`=1 when `hcnt` < 2*IMG_WIDTH, otherwise 0.
  - Pixel x = `hcnt`>>1. y = active line index 0..IMG_HEIGHT-1.
  - `data` = luma when `hcnt[0]`=0, 0x80 when `hcnt[0]`=1.
  - `data` = 0x00 whenever `href`=0.
- Luma Y (8-bit, truncating):
  - Ramp: Y = x[7:0].
  - Bars: Y = (x/80)*36, giving 0..252.
  - Checker: Y = 0xF0 if x[4]^y[4], else 0x10.
  - Diagonal: Y = (x+y+frame_cnt)[7:0].
- `vsync`=1 for all bytes of the VSYNC state, 0 elsewhere. `href` is 0 outside ACTIVE.

## Timing
- Reset values: `vsync`=0, `href`=0, `data`=0x00, `frame_start`=0, `busy`=0, state IDLE, all counters 0.
- Outputs are registered and change only after the rising edge of `clk`. The capture side samples them on the next rising edge.
- Reset assertion clears all outputs immediately (asynchronously), including mid-frame. After release, the block restarts from IDLE.
- Cycle after `enable` is first sampled high in IDLE: `vsync`=1 and `frame_start`=1 (one cycle only).
- Frame period at defaults: 510 lines * 1568 = 799,680 cycles.
- First `href` rise is (VSYNC_LINES+V_BACK)*LINE_BYTES cycles after the `vsync` rise (31,360 at defaults).
- Frames run back-to-back: the last VFRONT byte is followed directly by a VSYNC byte, with no idle gap.

## Structure
- Shared package `ov7670_emu_pkg` holds:
  - State enum.
  - Pattern enum (PAT_RAMP, PAT_BARS, PAT_CHECKER, PAT_DIAG).
  - CHROMA_BYTE = 8'h80.
  - Checker levels 0xF0/0x10.
  - Bar width 80 and bar step 36.
- Sub-module `ov7670_emu_luma`: purely combinational (pattern, x, y, frame_cnt) -> Y.
- Top-level emulator: FSM, counters and output registers.

## Test plan
Small bench parameters: IMG_WIDTH=8, IMG_HEIGHT=4, H_BLANK=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1. LINE_BYTES=20, frame = 7 lines = 140 cycles.
- Reset and enable: hold `reset_n`=0 -> all outputs 0. Release, set `enable`=1 -> next cycle `vsync`=1 and `frame_start`=1, `vsync` high for exactly 20 cycles, next `vsync` rise 140 cycles later.
- Ramp pattern, first active line: `href` high 16 cycles. Data sequence = 00,80,01,80,…,07,80, then 4 bytes of 0x00 with `href`=0.
- Checker pattern, defaults: pixel (16,0) luma 0xF0, pixel (0,16) luma 0xF0, pixel (16,16) luma 0x10.
- `enable` dropped during the 2nd active line: frame completes, 140 total cycles from `vsync` rise. Then `busy`=0, `vsync`/`href` stay 0.
- `pattern_sel` changed 0->2 mid-frame: current frame remains ramp; next frame is checker.
- Reset mid-ACTIVE: `href`, `data`, `vsync` go to 0 without a clock edge. With `enable`=1 after release, a full clean frame follows.
- Loopback: emulator feeding `ov7670_capture` at defaults, ramp pattern -> capture writes exactly 307,200 words per frame, addresses 0..307199.
